// File: rtl/cfg_initiator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cfg_initiator : issues one config write per command to a UART or VGA target
// Revision: 1.0
// ---------------------------------------------------------------------------
module cfg_initiator #(
  parameter int WIDTH_CONFIG_ADDR = 2,
  parameter int WIDTH_CONFIG_DATA = 8,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [WIDTH_CONFIG_ADDR-1:0] cmd_addr,
  input  logic [WIDTH_CONFIG_DATA-1:0] cmd_data,
  output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
  output logic [WIDTH_CONFIG_DATA-1:0] c_data,
  output logic                         c_valid,
  input  logic                         c_UART_ready,
  input  logic                         c_VGA_ready,
  output logic                         done,
  output logic [1:0]                   status
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_UART = WIDTH_CONFIG_ADDR'(1);
  localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_VGA  = WIDTH_CONFIG_ADDR'(2);
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BAD     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [WIDTH_CONFIG_ADDR-1:0]   addr_q, addr_d;
  logic [WIDTH_CONFIG_DATA-1:0]   data_q, data_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           done_q, done_d;
  logic [1:0]                     status_q, status_d;
  logic                           sel_ready;
  logic                           timeout_hit;

  // Only meaningful while busy, when addr_q is known to be UART or VGA.
  assign sel_ready   = (addr_q == ADDR_UART) ? c_UART_ready : c_VGA_ready;
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    status_d = status_q;
    c_valid  = 1'b0;

    if (state_q != IDLE && !timeout_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // In each wait state the awaited transition is tested before the timeout.
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          data_d = cmd_data;
          cnt_d  = '0;
          if (cmd_addr == ADDR_UART || cmd_addr == ADDR_VGA) begin
            state_d = ISSUE;
          end else begin
            done_d   = 1'b1;
            status_d = ST_BAD;
          end
        end
      end
      ISSUE: begin
        if (sel_ready) begin
          c_valid = 1'b1;
          state_d = ACK;
        end else if (timeout_hit) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          status_d = ST_TIMEOUT;
        end
      end
      ACK: begin
        if (!sel_ready) begin
          state_d = RELEASE;
        end else if (timeout_hit) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          status_d = ST_TIMEOUT;
        end
      end
      RELEASE: begin
        if (sel_ready) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          status_d = ST_OK;
        end else if (timeout_hit) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          status_d = ST_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign c_addr    = addr_q;
  assign c_data    = data_q;
  assign done      = done_q;
  assign status    = status_q;

endmodule
`default_nettype wire
